// File: rtl/mat_pkg.sv
// Shared widths, FSM state encoding and the saturating hit-counter helper
// for the feature-point matching sequencer.
package mat_pkg;

  localparam int PIX_W   = 64;
  localparam int DB_W    = 288;
  localparam int COORD_W = 18;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } mat_state_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == {CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/mat_controller.sv
// Feature-point matching sequencer: walks DB entries through the external
// matching datapath one per cycle, stopping at the first hit.
module mat_controller
  import mat_pkg::*;
#(
  parameter int DB_DEPTH = 16,
  parameter int ADDR_W   = $clog2(DB_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fpValid,
  output logic                 fpReady,
  input  logic [PIX_W-1:0]     fpPixel,
  input  logic [COORD_W-1:0]   fpCoord,
  output logic                 dbRdEn,
  output logic [ADDR_W-1:0]    dbAddr,
  input  logic [DB_W-1:0]      dbData,
  output logic [PIX_W-1:0]     matAdj,
  output logic [DB_W-1:0]      matDb,
  input  logic                 matPoint,
  output logic                 resValid,
  input  logic                 resReady,
  output logic                 resHit,
  output logic [ADDR_W-1:0]    resIndex,
  output logic [COORD_W-1:0]   resCoord,
  output logic                 busy,
  output logic [CNT_W-1:0]     matchCount
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  mat_state_t        stateR;
  mat_state_t        nextStateS;
  logic [ADDR_W-1:0] idxR;
  logic              lastIdxS;

  assign lastIdxS = (idxR == LAST_IDX);

  // Next-state decode and the state-driven DB/handshake strobes
  always_comb begin
    nextStateS = stateR;
    fpReady    = 1'b0;
    busy       = 1'b1;
    resValid   = 1'b0;
    dbRdEn     = 1'b0;
    dbAddr     = {ADDR_W{1'b0}};
    matDb      = {DB_W{1'b0}};
    case (stateR)
      IDLE: begin
        fpReady = 1'b1;
        busy    = 1'b0;
        if (fpValid) begin
          nextStateS = READ;
        end else begin
          nextStateS = IDLE;
        end
      end
      READ: begin
        dbRdEn     = 1'b1;
        dbAddr     = {ADDR_W{1'b0}};
        nextStateS = CHECK;
      end
      CHECK: begin
        matDb = dbData;
        // The last-entry exit is decided before any increment, so idxR never wraps
        if (matPoint || lastIdxS) begin
          nextStateS = DONE;
        end else begin
          dbRdEn     = 1'b1;
          dbAddr     = idxR + ONE_IDX;
          nextStateS = CHECK;
        end
      end
      DONE: begin
        resValid = 1'b1;
        if (resReady) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = DONE;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // State, index counter, captured point and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR     <= IDLE;
      idxR       <= {ADDR_W{1'b0}};
      matAdj     <= {PIX_W{1'b0}};
      resCoord   <= {COORD_W{1'b0}};
      resHit     <= 1'b0;
      resIndex   <= {ADDR_W{1'b0}};
      matchCount <= {CNT_W{1'b0}};
    end else begin
      stateR <= nextStateS;
      case (stateR)
        IDLE: begin
          if (fpValid) begin
            matAdj   <= fpPixel;
            resCoord <= fpCoord;
          end
        end
        READ: begin
          idxR <= {ADDR_W{1'b0}};
        end
        CHECK: begin
          if (matPoint) begin
            resHit     <= 1'b1;
            resIndex   <= idxR;
            matchCount <= satInc(matchCount);
          end else if (lastIdxS) begin
            resHit   <= 1'b0;
            resIndex <= {ADDR_W{1'b0}};
          end else begin
            idxR <= idxR + ONE_IDX;
          end
        end
        default: begin
          idxR <= idxR;
        end
      endcase
    end
  end

endmodule

// File: doc/mat_controller.md
# mat_controller

Sequencer for the feature-point matching stage. It accepts one feature point at a time: eight adjacent frame-buffer pixels plus a coordinate. It then streams DB entries from the synchronous DB memory through the external combinational matching datapath, one entry per cycle, and stops at the first hit. It reports hit/miss, the matching DB index and the coordinate on a result handshake, and keeps a running hit count for the host.

## Interface
Parameters:
- DB_DEPTH, 16: number of 288-bit DB entries; must be at least 2.
- ADDR_W, $clog2(DB_DEPTH): DB address and index width (derived).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- fpValid, in, 1: feature point offered.
- fpReady, out, 1: controller can accept a point. High only in IDLE.
- fpPixel, in, 64: eight adjacent pixels, byte 0 at [7:0].
- fpCoord, in, 18: {y[8:0], x[8:0]}.
- dbRdEn, out, 1: DB read strobe.
- dbAddr, out, ADDR_W: DB read address.
- dbData, in, 288: DB word, valid the cycle after dbRdEn.
- matAdj, out, 64: pixels driven to the datapath.
- matDb, out, 288: DB word driven to the datapath.
- matPoint, in, 1: datapath match result (combinational from matAdj/matDb).
- resValid, out, 1: result available.
- resReady, in, 1: consumer accepts the result.
- resHit, out, 1: 1 = match found.
- resIndex, out, ADDR_W: index of the matching entry; 0 on a miss.
- resCoord, out, 18: coordinate of the point that was processed.
- busy, out, 1: high whenever the state is not IDLE.
- matchCount, out, 16: total hits since reset, saturating.

## Operation
- States: IDLE, READ, CHECK, DONE.
- IDLE:
  - fpReady=1.
  - On fpValid&fpReady: register fpPixel into the matAdj register and fpCoord into the coordinate register; go to READ.
- READ (1 cycle): dbRdEn=1, dbAddr=0, internal index k←0; go to CHECK.
- CHECK: matDb=dbData (entry k); matPoint is sampled this cycle.
  - matPoint=1: resHit←1, resIndex←k, matchCount←matchCount+1 (holds at 0xFFFF); dbRdEn=0; go to DONE.
  - matPoint=0 and k=DB_DEPTH-1: resHit←0, resIndex←0; go to DONE.
  - Otherwise: dbRdEn=1, dbAddr=k+1, k←k+1; stay in CHECK.
- DONE:
  - resValid=1. resHit, resIndex and resCoord stay stable until the handshake.
  - On resValid&resReady: go to IDLE.
  - fpReady stays 0, so a new point never overlaps a pending result.
- matDb=0 outside CHECK.
- matAdj holds the accepted pixels from acceptance until the next acceptance.
- dbRdEn=0 in IDLE and DONE. No speculative read is issued past a hit or past the last entry.
- The index counter is ADDR_W wide and never wraps, because the k=DB_DEPTH-1 exit check comes first.
- fpValid arriving in DONE is ignored until the state is IDLE; the upstream holds it.

## Timing
- Reset values: state IDLE, fpReady=1, busy=0, dbRdEn=0, dbAddr=0, matAdj=0, matDb=0, resValid=0, resHit=0, resIndex=0, resCoord=0, matchCount=0.
- Reset during READ/CHECK/DONE: a pending result is dropped, the in-flight DB read is discarded, and the next cycle is IDLE.
- Latency, counted from the acceptance edge (cycle 0):
  - READ in cycle 1.
  - Entry k is checked in cycle 2+k.
  - resValid rises in cycle 3+k for a hit at k, or in cycle DB_DEPTH+2 for a miss.
- Throughput: one DB entry per cycle in CHECK. Back-to-back points cost at least one IDLE cycle after the result handshake.
- Simultaneous reset and handshake: reset wins.
- resReady held high: DONE lasts exactly 1 cycle.

## Structure
- Package mat_pkg holds:
  - constants PIX_W=64, DB_W=288, COORD_W=18, CNT_W=16;
  - typedef mat_state_t {IDLE, READ, CHECK, DONE}.
- Single module: FSM, index counter, hit counter and registers.
- The matching datapath stays an external sibling instance wired through matAdj/matDb/matPoint. No sub-module inside mat_controller.
- The bench instantiates mat_controller, the existing datapath and a 1-cycle-latency DB memory model.

## Test plan
- Reset then idle: all outputs at their reset values; fpReady=1, busy=0.
- Hit at index 0: pixels all 0x64, DB entry 0 with byte 0 = 0x6E (diff 10), DB_DEPTH=16 → resValid in cycle 3, resHit=1, resIndex=0, matchCount=1.
- Hit at index 5: entries 0–4 all 0x00 (0x00−0x64 wraps to 156, no match), entry 5 byte 3 = 0x70 → dbRdEn seen for addresses 0..5 only, resValid in cycle 8, resIndex=5.
- Full miss: all entries 0x00, fpCoord={9'd12, 9'd200} → resValid in cycle 18, resHit=0, resIndex=0, resCoord echoed, matchCount unchanged.
- Backpressure and overlap: resReady=0 for 10 cycles with fpValid held high → result stable, fpReady=0 throughout; the second point is accepted only after the handshake plus one IDLE cycle.
- Reset mid-CHECK (cycle 4) → IDLE the next cycle, resValid never asserted, matchCount retains no partial update; a new point then processes normally.
